// File: rtl/uart_pkg.sv
// Shared definitions for the AHB-Lite UART: register map,
// STATUS bit layout and serial line FSM encodings.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_FERR     = 6;
    localparam int ST_TX_BUSY  = 7;
    localparam int ST_RX_LEVEL = 8;
    localparam int ST_TX_LEVEL = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_100mhz,
    input  logic                   sys_rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk_100mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_uart_lite.sv
// AHB-Lite UART, 8N1 with 16x oversampling, TX/RX FIFOs,
// programmable baud divisor and a registered level interrupt.
module ahb_uart_lite
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 54
) (
    input  logic                  clk_100mhz,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [31:0]           hwdata,
    output logic [31:0]           hrdata,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic                  hsel,
    output logic                  hready,
    output logic                  hresp,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic                  irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    logic          dp_valid;
    logic          dp_write;
    logic [1:0]    dp_addr;
    logic [15:0]   baud;
    logic [2:0]    ctrl;
    logic          tx_ovf;
    logic          rx_ovr;
    logic          ferr;
    logic [31:0]   status;

    logic          data_wr, data_rd, stat_wr, baud_wr, ctrl_wr;
    logic          tx_ovf_set, rx_ovr_set;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [LW-1:0] tx_level;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [LW-1:0] rx_level;

    logic [15:0]   div_eff;
    logic [15:0]   tick_cnt;
    logic          tick;

    tx_state_t     tx_state, tx_next;
    logic [3:0]    tx_tcnt;
    logic [2:0]    tx_bcnt;
    logic [7:0]    tx_shift;
    logic          tx_load;
    logic          tx_bit_end;
    logic          tx_busy;

    rx_state_t     rx_state, rx_next;
    logic [3:0]    rx_tcnt;
    logic [2:0]    rx_bcnt;
    logic [7:0]    rx_shift;
    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_fall, rx_mid, rx_bit_end, ferr_set;

    logic          unused_ok;

    assign hready    = 1'b1;
    assign hresp     = 1'b0;
    assign unused_ok = ^{haddr[ADDR_WIDTH-1:4], haddr[1:0],
                         hwdata[31:16], htrans[0]};

    assign data_wr = dp_valid & dp_write & (dp_addr == UART_DATA);
    assign data_rd = dp_valid & ~dp_write & (dp_addr == UART_DATA);
    assign stat_wr = dp_valid & dp_write & (dp_addr == UART_STATUS);
    assign baud_wr = dp_valid & dp_write & (dp_addr == UART_BAUD);
    assign ctrl_wr = dp_valid & dp_write & (dp_addr == UART_CTRL);

    assign tx_push    = data_wr;
    assign rx_pop     = data_rd & ~rx_empty;
    assign tx_ovf_set = data_wr & tx_full & ~tx_pop;
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_100mhz (clk_100mhz),
        .sys_rst_n  (sys_rst_n),
        .push       (tx_push),
        .push_data  (hwdata[7:0]),
        .pop        (tx_pop),
        .pop_data   (tx_head),
        .full       (tx_full),
        .empty      (tx_empty),
        .level      (tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_100mhz (clk_100mhz),
        .sys_rst_n  (sys_rst_n),
        .push       (rx_push),
        .push_data  (rx_shift),
        .pop        (rx_pop),
        .pop_data   (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .level      (rx_level)
    );

    // AHB address phase capture and register state
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            baud     <= 16'(DEFAULT_DIV);
            ctrl     <= '0;
            tx_ovf   <= 1'b0;
            rx_ovr   <= 1'b0;
            ferr     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            dp_valid <= hsel & htrans[1];
            if (hsel && htrans[1]) begin
                dp_addr  <= haddr[3:2];
                dp_write <= hwrite;
            end
            if (baud_wr) begin
                baud <= hwdata[15:0];
            end
            if (ctrl_wr) begin
                ctrl <= hwdata[2:0];
            end
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(stat_wr & hwdata[ST_TX_OVF]));
            rx_ovr <= rx_ovr_set | (rx_ovr & ~(stat_wr & hwdata[ST_RX_OVR]));
            ferr   <= ferr_set   | (ferr   & ~(stat_wr & hwdata[ST_FERR]));
            irq    <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty)
                    | (ctrl[2] & (tx_ovf | rx_ovr | ferr));
        end
    end

    always_comb begin
        status = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_FERR]     = ferr;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_RX_LEVEL +: 5] = 5'(rx_level);
        status[ST_TX_LEVEL +: 5] = 5'(tx_level);
    end

    always_comb begin
        hrdata = '0;
        if (dp_valid && !dp_write) begin
            unique case (dp_addr)
                UART_DATA:   hrdata = {24'b0, rx_empty ? 8'h00 : rx_head};
                UART_STATUS: hrdata = status;
                UART_BAUD:   hrdata = {16'b0, baud};
                UART_CTRL:   hrdata = {29'b0, ctrl};
            endcase
        end
    end

    // Oversampling tick; a BAUD write restarts the period
    assign div_eff = (baud == 16'd0) ? 16'd1 : baud;
    assign tick    = (tick_cnt >= div_eff - 16'd1);

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (baud_wr || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Transmitter
    assign tx_bit_end = tick & (tx_tcnt == LAST_TICK);
    assign tx_pop     = tx_load;

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_load) begin
                tx_shift <= tx_head;
                tx_tcnt  <= '0;
                tx_bcnt  <= '0;
            end else if (tick && tx_state != TX_IDLE) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_state == TX_DATA && tx_tcnt == LAST_TICK) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bcnt  <= tx_bcnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_next = TX_START;
                    tx_load = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end && tx_bcnt == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_next = tx_empty ? TX_IDLE : TX_START;
                    tx_load = ~tx_empty;
                end
            end
        endcase
    end

    always_comb begin
        tx_busy = (tx_state != TX_IDLE);
        unique case (tx_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    // Receiver: synchronizer plus one extra flop for edge detect
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall    = rx_prev & ~rx_sync;
    assign rx_mid     = (rx_state == RX_START) & (rx_tcnt == MID_TICK);
    assign rx_bit_end = tick & (rx_tcnt == LAST_TICK);

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_tcnt <= '0;
                rx_bcnt <= '0;
            end else if (tick) begin
                rx_tcnt <= rx_mid ? 4'd0 : rx_tcnt + 4'd1;
                if (rx_state == RX_DATA && rx_tcnt == LAST_TICK) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bcnt  <= rx_bcnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        rx_next  = rx_state;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_next = RX_START;
            end
            RX_START: begin
                if (tick && rx_mid) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_bcnt == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_next  = RX_IDLE;
                    rx_push  = rx_sync;
                    ferr_set = ~rx_sync;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_uart_lite.sv
// Directed self-checking bench for ahb_uart_lite: register access,
// TX/RX framing, overflow, frame error, false start and reset abort.
module tb_ahb_uart_lite;

    logic        clk_100mhz = 1'b0;
    logic        sys_rst_n;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hsel;
    logic        hready;
    logic        hresp;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic [159:0] irq_trace;
    logic [159:0] tx_obs;
    logic [159:0] tx_exp;
    logic [9:0]  tx_frame;
    int          lat;
    int          rise;

    always #5 clk_100mhz = ~clk_100mhz;

    ahb_uart_lite dut (
        .clk_100mhz (clk_100mhz),
        .sys_rst_n  (sys_rst_n),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hsel       (hsel),
        .hready     (hready),
        .hresp      (hresp),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_100mhz);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        @(negedge clk_100mhz);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_100mhz);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        @(negedge clk_100mhz);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 160; k++) begin
            @(negedge clk_100mhz);
            irq_trace[k] = irq;
            uart_rx = frame[k/16];
        end
        @(negedge clk_100mhz);
        uart_rx = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        haddr = '0; hwdata = '0; hwrite = 1'b0;
        htrans = 2'b00; hsel = 1'b0; uart_rx = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_hrdata", hrdata, 32'h0);
        sys_rst_n = 1'b1;

        ahb_read(32'h0, rd);  check("rst_data", rd, 32'h0);
        ahb_read(32'h4, rd);  check("rst_status", rd, 32'h6);
        ahb_read(32'h8, rd);  check("rst_baud", rd, 32'd54);
        ahb_read(32'hC, rd);  check("rst_ctrl", rd, 32'h0);

        // TX 0x55 at BAUD=1
        ahb_write(32'h8, 32'd1);
        ahb_write(32'h0, 32'h55);
        lat = 0;
        while (uart_tx !== 1'b0 && lat < 10) begin
            @(negedge clk_100mhz);
            lat++;
        end
        check("tx_start_latency_le3", lat <= 3, 1'b1);
        tx_frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 160; k++) begin
            tx_exp[k] = tx_frame[k/16];
        end
        tx_obs[0] = uart_tx;
        for (int k = 1; k < 160; k++) begin
            @(negedge clk_100mhz);
            tx_obs[k] = uart_tx;
        end
        check("tx_frame_0x55", tx_obs, tx_exp);
        ahb_read(32'h4, rd);  check("tx_done_status", rd, 32'h6);

        // RX 0xA3
        send_rx(8'hA3, 1'b1);
        ahb_read(32'h4, rd);  check("rx_status_level1", rd, 32'h102);
        ahb_read(32'h0, rd);  check("rx_data_a3", rd, 32'hA3);
        ahb_read(32'h4, rd);  check("rx_status_empty", rd, 32'h6);

        // Frame error with error interrupt enabled
        ahb_write(32'hC, 32'h4);
        send_rx(8'h5A, 1'b0);
        rise = -1;
        for (int k = 0; k < 160; k++) begin
            if (irq_trace[k] && rise < 0) rise = k;
        end
        check("ferr_irq_rise_in_stop", rise >= 144 && rise <= 159, 1'b1);
        check("ferr_irq_high", irq, 1'b1);
        ahb_read(32'h4, rd);  check("ferr_status", rd, 32'h46);
        ahb_write(32'h4, 32'h40);
        ahb_read(32'h4, rd);  check("ferr_w1c_status", rd, 32'h6);
        check("ferr_w1c_irq", irq, 1'b0);

        // 4-cycle glitch is a false start
        @(negedge clk_100mhz);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk_100mhz);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk_100mhz);
        ahb_read(32'h4, rd);  check("glitch_status", rd, 32'h6);
        check("glitch_irq", irq, 1'b0);

        // TX overflow with the transmitter held off by a long period
        ahb_write(32'h8, 32'd2000);
        for (int i = 0; i < 17; i++) begin
            ahb_write(32'h0, 32'h10 + i);
        end
        ahb_read(32'h4, rd);  check("ovf_status", rd, 32'h0010_0015);
        check("ovf_irq", irq, 1'b1);
        ahb_write(32'h4, 32'h10);
        ahb_read(32'h4, rd);  check("ovf_w1c_status", rd, 32'h0010_0005);
        check("ovf_w1c_irq", irq, 1'b0);

        // Reset in the middle of a frame (byte 0x10: first 80 cycles low)
        ahb_write(32'h8, 32'd1);
        repeat (40) @(negedge clk_100mhz);
        check("midframe_tx_low", uart_tx, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        check("reset_tx_high", uart_tx, 1'b1);
        repeat (2) @(negedge clk_100mhz);
        sys_rst_n = 1'b1;
        ahb_read(32'h4, rd);  check("reset_status", rd, 32'h6);
        ahb_read(32'h8, rd);  check("reset_baud", rd, 32'd54);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
